// File: rtl/pc_stack_unit.sv
// Program counter with PC-relative branch and a hardware call/return stack.
// All PC and stack updates are qualified by flash_ready; the sticky error flags clear via err_clr.
module pc_stack_unit #(
  parameter int unsigned                ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = 12'h080,
  parameter logic [ADDR_WIDTH-1:0]      BOOT_LIMIT   = 12'h100,
  parameter int unsigned                STACK_DEPTH  = 8,
  parameter int unsigned                OFFSET_WIDTH = 8,
  localparam int unsigned               SP_W         = $clog2(STACK_DEPTH),
  localparam int unsigned               DEPTH_W      = SP_W + 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    flash_ready,
  input  logic                    pc_inc,
  input  logic                    pc_load,
  input  logic [ADDR_WIDTH-1:0]   pc_next,
  input  logic                    pc_rel,
  input  logic [OFFSET_WIDTH-1:0] rel_offset,
  input  logic                    pc_call,
  input  logic                    pc_ret,
  input  logic                    err_clr,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic                    bootstrapping,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic [DEPTH_W-1:0]      stack_depth,
  output logic                    stack_ovf,
  output logic                    stack_unf
);

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_REL,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, unf_q;
  logic                  ovf_set, unf_set, push_en;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_plus1, rel_ext, top_entry;
  logic [SP_W-1:0]       push_idx, top_idx;
  logic                  full, empty;
  cmd_e                  cmd;

  assign full      = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty     = (depth_q == '0);
  assign pc_plus1  = pc_q + ADDR_WIDTH'(1);
  assign rel_ext   = ADDR_WIDTH'(signed'(rel_offset));
  assign push_idx  = depth_q[SP_W-1:0];
  assign top_idx   = SP_W'(depth_q - DEPTH_W'(1));
  assign top_entry = stack_mem[top_idx];

  // Priority decode: only the highest-priority command is acted on.
  always_comb begin
    cmd = CMD_NONE;
    if      (pc_ret)  cmd = CMD_RET;
    else if (pc_call) cmd = CMD_CALL;
    else if (pc_load) cmd = CMD_LOAD;
    else if (pc_rel)  cmd = CMD_REL;
    else if (pc_inc)  cmd = CMD_INC;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (flash_ready) begin
      unique case (cmd)
        CMD_INC:  pc_d = pc_plus1;
        CMD_REL:  pc_d = pc_q + rel_ext;
        CMD_LOAD: pc_d = pc_next;
        CMD_CALL: begin
          pc_d = pc_next;
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        CMD_RET: begin
          if (empty) begin
            pc_d    = RESET_VECTOR;
            unf_set = 1'b1;
          end else begin
            pc_d    = top_entry;
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      // Set wins over a same-cycle clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (unf_set)      unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

  // NOTE: storage is not reset; depth_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= pc_plus1;
  end

  assign pc_out        = pc_q;
  assign bootstrapping = (pc_q < BOOT_LIMIT);
  assign stack_full    = full;
  assign stack_empty   = empty;
  assign stack_depth   = depth_q;
  assign stack_ovf     = ovf_q;
  assign stack_unf     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with hand-computed expected values.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        flash_ready;
  logic        pc_inc, pc_load, pc_rel, pc_call, pc_ret, err_clr;
  logic [11:0] pc_next;
  logic [7:0]  rel_offset;
  logic [11:0] pc_out;
  logic        bootstrapping, stack_full, stack_empty, stack_ovf, stack_unf;
  logic [3:0]  stack_depth;

  int n_checks = 0;
  int n_pass   = 0;

  pc_stack_unit dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .flash_ready  (flash_ready),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .pc_rel       (pc_rel),
    .rel_offset   (rel_offset),
    .pc_call      (pc_call),
    .pc_ret       (pc_ret),
    .err_clr      (err_clr),
    .pc_out       (pc_out),
    .bootstrapping(bootstrapping),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_depth  (stack_depth),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic idle();
    {pc_inc, pc_load, pc_rel, pc_call, pc_ret, err_clr} = '0;
    pc_next    = '0;
    rel_offset = '0;
  endtask

  // One clock edge, then sample 1 time unit later and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_inc();                 pc_inc = 1;  tick(); endtask
  task automatic do_load(input logic [11:0] a); pc_load = 1; pc_next = a; tick(); endtask
  task automatic do_rel(input logic [7:0] o);   pc_rel = 1;  rel_offset = o; tick(); endtask
  task automatic do_call(input logic [11:0] a); pc_call = 1; pc_next = a; tick(); endtask
  task automatic do_ret();                 pc_ret = 1;  tick(); endtask

  logic [11:0] ret_addr [8];

  initial begin
    idle();
    flash_ready = 1;
    arst_n      = 0;
    #12;
    check("rst_pc",    pc_out, 12'h080);
    check("rst_depth", stack_depth, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full",  stack_full, 0);
    check("rst_ovf",   stack_ovf, 0);
    check("rst_unf",   stack_unf, 0);
    check("rst_boot",  bootstrapping, 1);
    arst_n = 1;
    @(negedge clk);

    do_inc(); check("inc1", pc_out, 12'h081);
    do_inc(); check("inc2", pc_out, 12'h082);
    do_inc(); check("inc3", pc_out, 12'h083);
    check("inc_boot",  bootstrapping, 1);
    check("inc_empty", stack_empty, 1);

    do_load(12'h0FF); check("boot_before", bootstrapping, 1);
    do_inc();         check("inc_100", pc_out, 12'h100);
    check("boot_fall", bootstrapping, 0);
    do_load(12'hFFF); check("load_fff", pc_out, 12'hFFF);
    do_inc();         check("inc_wrap", pc_out, 12'h000);

    do_load(12'h105);
    do_rel(8'hFB); check("rel_neg", pc_out, 12'h100);
    do_rel(8'h7F); check("rel_pos", pc_out, 12'h17F);
    flash_ready = 0;
    pc_inc = 1; tick();
    pc_inc = 1; tick(); check("hold_inc", pc_out, 12'h17F);
    do_call(12'h555); check("hold_call_pc", pc_out, 12'h17F);
    check("hold_call_depth", stack_depth, 0);
    flash_ready = 1;
    do_load(12'h002);
    do_rel(8'hFB); check("rel_wrap_down", pc_out, 12'hFFD);
    do_rel(8'h05); check("rel_wrap_up", pc_out, 12'h002);

    // Priority among the lower commands.
    pc_load = 1; pc_next = 12'h3A0; pc_rel = 1; rel_offset = 8'h10; pc_inc = 1; tick();
    check("prio_load", pc_out, 12'h3A0);
    pc_rel = 1; rel_offset = 8'h10; pc_inc = 1; tick();
    check("prio_rel", pc_out, 12'h3B0);
    pc_call = 1; pc_load = 1; pc_next = 12'h3C0; tick();
    check("prio_call_depth", stack_depth, 1);
    do_ret(); check("prio_call_ret", pc_out, 12'h3B1);

    // Nested calls.
    do_load(12'h200);
    do_call(12'h300); check("nest_pc1", pc_out, 12'h300); check("nest_d1", stack_depth, 1);
    do_call(12'h400); check("nest_pc2", pc_out, 12'h400); check("nest_d2", stack_depth, 2);
    do_ret();         check("nest_ret1", pc_out, 12'h301); check("nest_d3", stack_depth, 1);
    do_ret();         check("nest_ret2", pc_out, 12'h201); check("nest_d4", stack_depth, 0);
    check("nest_empty", stack_empty, 1);

    // Back-to-back call then ret.
    do_load(12'h050);
    do_call(12'h700);
    do_ret(); check("b2b_ret", pc_out, 12'h051);

    // Fill, overflow, drain.
    do_load(12'h500);
    ret_addr[0] = 12'h501;
    for (int k = 1; k < 8; k++) ret_addr[k] = 12'h600 + 12'((k - 1) * 16 + 1);
    for (int k = 0; k < 8; k++) begin
      do_call(12'h600 + 12'(k * 16));
      check("fill_full_early", stack_full, (k == 7) ? 1 : 0);
    end
    check("fill_depth", stack_depth, 8);
    check("fill_ovf0", stack_ovf, 0);
    do_call(12'h680);
    check("ovf_pc", pc_out, 12'h680);
    check("ovf_flag", stack_ovf, 1);
    check("ovf_depth", stack_depth, 8);
    for (int k = 7; k >= 0; k--) begin
      do_ret();
      check("drain_pc", pc_out, ret_addr[k]);
    end
    check("drain_empty", stack_empty, 1);
    check("ovf_sticky", stack_ovf, 1);
    flash_ready = 0; err_clr = 1; tick();
    check("ovf_clr", stack_ovf, 0);
    check("clr_hold_pc", pc_out, 12'h501);
    flash_ready = 1;

    // Underflow and ret priority.
    do_load(12'h234);
    do_ret(); check("unf_pc", pc_out, 12'h080); check("unf_flag", stack_unf, 1);
    check("unf_depth", stack_depth, 0);
    do_load(12'h234);
    do_call(12'h300);
    pc_ret = 1; pc_inc = 1; pc_call = 1; pc_load = 1; pc_next = 12'h777; tick();
    check("prio_ret_pc", pc_out, 12'h235);
    check("prio_ret_depth", stack_depth, 0);
    pc_ret = 1; pc_inc = 1; tick();
    check("prio_ret_empty", pc_out, 12'h080);
    pc_ret = 1; err_clr = 1; tick();
    check("unf_set_wins", stack_unf, 1);
    err_clr = 1; tick();
    check("unf_clr", stack_unf, 0);

    // Asynchronous reset mid-operation.
    do_load(12'h400);
    do_call(12'h450);
    do_call(12'h460);
    #2 arst_n = 0;
    #1;
    check("arst_pc", pc_out, 12'h080);
    check("arst_depth", stack_depth, 0);
    check("arst_empty", stack_empty, 1);
    #4 arst_n = 1;
    @(negedge clk);
    do_ret();
    check("arst_unf_ret", stack_unf, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
